bf_array_core: RTL and testbench

//  Parametrised successor to the 8-element, 2-beam beamformer front end. Computes per-element

---
 rtl/bf_array_core.sv | 184 ++++++++++++++++++
 tb/tb_bf_array_core.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bf_array_core.sv
// Beamformer front end: per-channel complex weighted beam sums, fs/4 LO mixing,
// double-buffered weights with phase-aligned atomic commit.
module bf_array_core #(
    parameter int unsigned NUM_CH    = 8,
    parameter int unsigned NUM_BEAMS = 2,
    parameter int unsigned DW        = 8,
    parameter int unsigned WW        = 5,
    localparam int unsigned OW = DW + WW + $clog2(NUM_BEAMS) + 2,
    localparam int unsigned CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int unsigned BW = (NUM_BEAMS > 1) ? $clog2(NUM_BEAMS) : 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_BEAMS*DW-1:0] vin_i,
    input  logic [NUM_BEAMS*DW-1:0] vin_q,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [CW-1:0]           wr_ch,
    input  logic [BW-1:0]           wr_beam,
    input  logic                    wr_sel,
    input  logic [WW-1:0]           wr_data,
    input  logic                    commit_req,
    output logic                    commit_done,
    input  logic [1:0]              lo_mode,
    input  logic                    lo_sync,
    input  logic [NUM_CH-1:0]       ch_en,
    output logic [1:0]              lo_phase,
    output logic [NUM_CH*OW-1:0]    mix_o
);

    typedef enum logic {IDLE, PEND} state_t;

    state_t state, state_nx;
    logic   commit_fire;
    logic   wr_fire;
    logic [1:0] phase;

    logic signed [WW-1:0] sh_cos  [NUM_CH][NUM_BEAMS];
    logic signed [WW-1:0] sh_sin  [NUM_CH][NUM_BEAMS];
    logic signed [WW-1:0] act_cos [NUM_CH][NUM_BEAMS];
    logic signed [WW-1:0] act_sin [NUM_CH][NUM_BEAMS];

    logic signed [OW-1:0] vx_i   [NUM_BEAMS];
    logic signed [OW-1:0] vx_q   [NUM_BEAMS];
    logic signed [OW-1:0] wx_cos [NUM_CH][NUM_BEAMS];
    logic signed [OW-1:0] wx_sin [NUM_CH][NUM_BEAMS];

    logic signed [OW-1:0] s1_i    [NUM_CH];
    logic signed [OW-1:0] s1_q    [NUM_CH];
    logic signed [OW-1:0] s1_i_nx [NUM_CH];
    logic signed [OW-1:0] s1_q_nx [NUM_CH];
    logic signed [OW-1:0] mix_r   [NUM_CH];
    logic signed [OW-1:0] mix_nx  [NUM_CH];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // The copy waits for the phase-3 edge so new weights meet phase-0 data in stage 1.
    always_comb begin
        state_nx    = state;
        wr_ready    = 1'b0;
        commit_fire = 1'b0;
        case (state)
            IDLE: begin
                wr_ready = 1'b1;
                if (commit_req) state_nx = PEND;
            end
            PEND: begin
                if (phase == 2'd3 && !lo_sync) begin
                    commit_fire = 1'b1;
                    state_nx    = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign wr_fire = wr_valid && wr_ready &&
                     (32'(wr_ch) < NUM_CH) && (32'(wr_beam) < NUM_BEAMS);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sh_cos  <= '{default: '0};
            sh_sin  <= '{default: '0};
            act_cos <= '{default: '0};
            act_sin <= '{default: '0};
        end else begin
            if (wr_fire) begin
                if (wr_sel) sh_sin[wr_ch][wr_beam] <= wr_data;
                else        sh_cos[wr_ch][wr_beam] <= wr_data;
            end
            if (commit_fire) begin
                act_cos <= sh_cos;
                act_sin <= sh_sin;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            commit_done <= 1'b0;
            phase       <= 2'd0;
        end else begin
            commit_done <= commit_fire;
            phase       <= lo_sync ? 2'd0 : phase + 2'd1;
        end
    end

    assign lo_phase = phase;

    always_comb begin
        for (int unsigned b = 0; b < NUM_BEAMS; b++) begin
            vx_i[b] = OW'($signed(vin_i[b*DW +: DW]));
            vx_q[b] = OW'($signed(vin_q[b*DW +: DW]));
        end
    end

    always_comb begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            for (int unsigned b = 0; b < NUM_BEAMS; b++) begin
                wx_cos[c][b] = OW'(act_cos[c][b]);
                wx_sin[c][b] = OW'(act_sin[c][b]);
            end
        end
    end

    always_comb begin : stage1_sum
        logic signed [OW-1:0] acc_i;
        logic signed [OW-1:0] acc_q;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            acc_i = '0;
            acc_q = '0;
            for (int unsigned b = 0; b < NUM_BEAMS; b++) begin
                acc_i = acc_i + vx_i[b] * wx_cos[c][b] - vx_q[b] * wx_sin[c][b];
                acc_q = acc_q + vx_i[b] * wx_sin[c][b] + vx_q[b] * wx_cos[c][b];
            end
            s1_i_nx[c] = acc_i;
            s1_q_nx[c] = acc_q;
        end
    end

    // Real part of (I + jQ) rotated by +/-90 deg per LO step.
    always_comb begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            mix_nx[c] = '0;
            if (ch_en[c]) begin
                if (lo_mode[1]) begin
                    mix_nx[c] = s1_i[c];
                end else begin
                    case (phase)
                        2'd0:    mix_nx[c] = s1_i[c];
                        2'd1:    mix_nx[c] = lo_mode[0] ? s1_q[c] : -s1_q[c];
                        2'd2:    mix_nx[c] = -s1_i[c];
                        default: mix_nx[c] = lo_mode[0] ? -s1_q[c] : s1_q[c];
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_i  <= '{default: '0};
            s1_q  <= '{default: '0};
            mix_r <= '{default: '0};
        end else begin
            s1_i  <= s1_i_nx;
            s1_q  <= s1_q_nx;
            mix_r <= mix_nx;
        end
    end

    always_comb begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            mix_o[c*OW +: OW] = mix_r[c];
        end
    end

endmodule

// File: tb/tb_bf_array_core.sv
// Bench for bf_array_core: default-parameter instance (a) and a 3-ch/4-beam instance (b),
// both checked every cycle against a complex-arithmetic reference model.
module tb_bf_array_core;

    logic clock = 1'b0;
    always #5 clock = ~clock;
    logic reset;

    int         vi [2][4];
    int         vq [2][4];
    logic       wr_valid [2];
    logic       wr_sel [2];
    logic       commit_req [2];
    logic       lo_sync [2];
    int         wr_ch [2];
    int         wr_beam [2];
    int         wr_data [2];
    int         lo_mode [2];
    logic [7:0] ch_en [2];

    logic [15:0]  vin_i0, vin_q0;
    logic [47:0]  vin_i1, vin_q1;
    logic [2:0]   wr_ch0;
    logic         wr_beam0;
    logic [4:0]   wr_data0;
    logic [1:0]   lo_mode0;
    logic [1:0]   wr_ch1, wr_beam1, lo_mode1;
    logic [7:0]   wr_data1;
    logic [2:0]   ch_en1;
    logic [127:0] mix0;
    logic [71:0]  mix1;
    logic         rdy0, rdy1, done0, done1;
    logic [1:0]   ph0, ph1;
    logic signed [63:0] obs0 [8];
    logic signed [63:0] obs1 [3];

    always_comb begin
        for (int b = 0; b < 2; b++) begin
            vin_i0[b*8 +: 8] = 8'(vi[0][b]);
            vin_q0[b*8 +: 8] = 8'(vq[0][b]);
        end
        for (int b = 0; b < 4; b++) begin
            vin_i1[b*12 +: 12] = 12'(vi[1][b]);
            vin_q1[b*12 +: 12] = 12'(vq[1][b]);
        end
        wr_ch0   = 3'(wr_ch[0]);
        wr_beam0 = 1'(wr_beam[0]);
        wr_data0 = 5'(wr_data[0]);
        lo_mode0 = 2'(lo_mode[0]);
        wr_ch1   = 2'(wr_ch[1]);
        wr_beam1 = 2'(wr_beam[1]);
        wr_data1 = 8'(wr_data[1]);
        lo_mode1 = 2'(lo_mode[1]);
        ch_en1   = ch_en[1][2:0];
    end

    always_comb begin
        for (int c = 0; c < 8; c++) obs0[c] = 64'($signed(mix0[c*16 +: 16]));
        for (int c = 0; c < 3; c++) obs1[c] = 64'($signed(mix1[c*24 +: 24]));
    end

    bf_array_core u_dut_a (
        .clock(clock), .reset(reset), .vin_i(vin_i0), .vin_q(vin_q0),
        .wr_valid(wr_valid[0]), .wr_ready(rdy0), .wr_ch(wr_ch0), .wr_beam(wr_beam0),
        .wr_sel(wr_sel[0]), .wr_data(wr_data0), .commit_req(commit_req[0]),
        .commit_done(done0), .lo_mode(lo_mode0), .lo_sync(lo_sync[0]),
        .ch_en(ch_en[0]), .lo_phase(ph0), .mix_o(mix0)
    );

    bf_array_core #(.NUM_CH(3), .NUM_BEAMS(4), .DW(12), .WW(8)) u_dut_b (
        .clock(clock), .reset(reset), .vin_i(vin_i1), .vin_q(vin_q1),
        .wr_valid(wr_valid[1]), .wr_ready(rdy1), .wr_ch(wr_ch1), .wr_beam(wr_beam1),
        .wr_sel(wr_sel[1]), .wr_data(wr_data1), .commit_req(commit_req[1]),
        .commit_done(done1), .lo_mode(lo_mode1), .lo_sync(lo_sync[1]),
        .ch_en(ch_en1), .lo_phase(ph1), .mix_o(mix1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: shadow/active weight tables, pending flag, LO phase, 2-deep pipe.
    longint m_shc [2][8][4];
    longint m_shs [2][8][4];
    longint m_acc [2][8][4];
    longint m_acs [2][8][4];
    longint m_i   [2][8];
    longint m_q   [2][8];
    longint m_mix [2][8];
    int     m_phase [2];
    bit     m_pend  [2];
    bit     m_done  [2];
    int     COS4 [4] = '{1, 0, -1, 0};
    int     SIN4 [4] = '{0, 1, 0, -1};

    function automatic int nch(input int k); return (k != 0) ? 3 : 8; endfunction
    function automatic int nb(input int k);  return (k != 0) ? 4 : 2; endfunction
    function automatic int dw(input int k);  return (k != 0) ? 12 : 8; endfunction
    function automatic int ww(input int k);  return (k != 0) ? 8 : 5; endfunction

    // Re{(I + jQ) * exp(+/- j*pi*p/2)}; up uses +, down uses -.
    function automatic longint lo_mix(input int mode, input int p, input longint i,
                                      input longint q);
        if (mode >= 2) return i;
        if (mode == 0) return i * COS4[p] - q * SIN4[p];
        return i * COS4[p] + q * SIN4[p];
    endfunction

    task automatic model_reset(input int k);
        for (int c = 0; c < 8; c++) begin
            for (int b = 0; b < 4; b++) begin
                m_shc[k][c][b] = 0; m_shs[k][c][b] = 0;
                m_acc[k][c][b] = 0; m_acs[k][c][b] = 0;
            end
            m_i[k][c] = 0; m_q[k][c] = 0; m_mix[k][c] = 0;
        end
        m_phase[k] = 0; m_pend[k] = 0; m_done[k] = 0;
    endtask

    task automatic model_step(input int k);
        int     p0;
        bit     pend0;
        longint si, sq;
        p0 = m_phase[k];
        pend0 = m_pend[k];
        for (int c = 0; c < nch(k); c++)
            m_mix[k][c] = ch_en[k][c] ? lo_mix(lo_mode[k], p0, m_i[k][c], m_q[k][c]) : 0;
        for (int c = 0; c < nch(k); c++) begin
            si = 0; sq = 0;
            for (int b = 0; b < nb(k); b++) begin
                si += vi[k][b] * m_acc[k][c][b] - vq[k][b] * m_acs[k][c][b];
                sq += vi[k][b] * m_acs[k][c][b] + vq[k][b] * m_acc[k][c][b];
            end
            m_i[k][c] = si; m_q[k][c] = sq;
        end
        if (wr_valid[k] && !pend0 && wr_ch[k] < nch(k) && wr_beam[k] < nb(k)) begin
            if (wr_sel[k]) m_shs[k][wr_ch[k]][wr_beam[k]] = wr_data[k];
            else           m_shc[k][wr_ch[k]][wr_beam[k]] = wr_data[k];
        end
        m_done[k] = 0;
        if (!pend0) begin
            m_pend[k] = commit_req[k];
        end else if (p0 == 3 && !lo_sync[k]) begin
            m_acc[k] = m_shc[k];
            m_acs[k] = m_shs[k];
            m_done[k] = 1;
            m_pend[k] = 0;
        end
        m_phase[k] = lo_sync[k] ? 0 : (p0 + 1) % 4;
    endtask

    task automatic compare(input int k);
        string s;
        s = (k != 0) ? "b" : "a";
        check({s, "_phase"}, 64'((k != 0) ? ph1 : ph0), 64'(m_phase[k]));
        check({s, "_ready"}, 64'((k != 0) ? rdy1 : rdy0), 64'(!m_pend[k]));
        check({s, "_done"}, 64'((k != 0) ? done1 : done0), 64'(m_done[k]));
        for (int c = 0; c < nch(k); c++)
            check($sformatf("%s_mix%0d", s, c), (k != 0) ? obs1[c] : obs0[c], m_mix[k][c]);
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
        for (int k = 0; k < 2; k++) begin
            if (!reset) model_reset(k);
            else        model_step(k);
            compare(k);
        end
    endtask

    task automatic idle(input int k);
        for (int b = 0; b < 4; b++) begin vi[k][b] = 0; vq[k][b] = 0; end
        wr_valid[k] = 0; wr_sel[k] = 0; commit_req[k] = 0; lo_sync[k] = 0;
        wr_ch[k] = 0; wr_beam[k] = 0; wr_data[k] = 0; lo_mode[k] = 0;
        ch_en[k] = 8'hFF;
    endtask

    task automatic rand_inputs(input int k);
        for (int b = 0; b < 4; b++) begin
            vi[k][b] = int'($urandom_range(0, (1 << dw(k)) - 1)) - (1 << (dw(k) - 1));
            vq[k][b] = int'($urandom_range(0, (1 << dw(k)) - 1)) - (1 << (dw(k) - 1));
        end
        wr_valid[k]   = ($urandom_range(0, 1) == 1);
        wr_ch[k]      = int'($urandom_range(0, (k != 0) ? 3 : 7));
        wr_beam[k]    = int'($urandom_range(0, (k != 0) ? 3 : 1));
        wr_sel[k]     = ($urandom_range(0, 1) == 1);
        wr_data[k]    = int'($urandom_range(0, (1 << ww(k)) - 1)) - (1 << (ww(k) - 1));
        commit_req[k] = ($urandom_range(0, 7) == 0);
        lo_sync[k]    = ($urandom_range(0, 15) == 0);
        lo_mode[k]    = int'($urandom_range(0, 3));
        ch_en[k]      = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        idle(0); idle(1);
        repeat (3) cycle();
        reset = 1'b1;
    endtask

    task automatic write_w(input int k, input int ch, input int beam, input int sel,
                           input int data);
        wr_valid[k] = 1; wr_ch[k] = ch; wr_beam[k] = beam;
        wr_sel[k] = (sel != 0); wr_data[k] = data;
        cycle();
        wr_valid[k] = 0;
    endtask

    // Returns at the sample right after the copy edge.
    task automatic commit_wait(input int k);
        bit seen;
        seen = 0;
        commit_req[k] = 1;
        cycle();
        commit_req[k] = 0;
        for (int n = 0; n < 12 && !seen; n++) begin
            cycle();
            seen = (k != 0) ? done1 : done0;
        end
        if (!seen) check("commit_timeout", 0, 1);
    endtask

    longint T2 [4] = '{150, 0, -150, 0};
    longint T4 [4] = '{0, -8192, 0, 8192};
    longint TD [4] = '{0, 4, 0, -4};
    longint TU [4] = '{0, -4, 0, 4};

    initial begin
        int done_cnt;
        reset = 1'b0;
        idle(0); idle(1);

        // Reset held with random inputs
        for (int n = 0; n < 5; n++) begin
            rand_inputs(0); rand_inputs(1);
            cycle();
            for (int c = 0; c < 8; c++) check("rst_mix", obs0[c], 0);
            check("rst_phase", 64'(ph0), 0);
            check("rst_ready", 64'(rdy0), 1);
            check("rst_done", 64'(done0), 0);
        end

        // Reset asserted while a commit is pending
        do_reset();
        commit_req[0] = 1;
        cycle();
        commit_req[0] = 0;
        #2 reset = 1'b0;
        cycle(); cycle();
        reset = 1'b1;
        done_cnt = 0;
        for (int n = 0; n < 8; n++) begin
            cycle();
            done_cnt += int'(done0);
        end
        check("rst_mid_commit_done", 64'(done_cnt), 0);
        check("rst_mid_commit_ready", 64'(rdy0), 1);

        // Single weight, single beam up-conversion
        do_reset();
        vi[0][0] = 10;
        write_w(0, 0, 0, 0, 15);
        commit_wait(0);
        cycle(); cycle();
        for (int n = 0; n < 8; n++) begin
            check("t2_mix0", obs0[0], T2[(m_phase[0] + 3) % 4]);
            check("t2_mix1", obs0[1], 0);
            cycle();
        end

        // Commit timing and write blocking while pending
        for (int n = 0; n < 8 && m_phase[0] != 1; n++) cycle();
        check("t3_start_phase", 64'(ph0), 1);
        commit_req[0] = 1;
        cycle();
        commit_req[0] = 0;
        wr_valid[0] = 1; wr_ch[0] = 1; wr_beam[0] = 0; wr_sel[0] = 0; wr_data[0] = 7;
        check("t3_ready_pend", 64'(rdy0), 0);
        done_cnt = 0;
        for (int n = 0; n < 8 && done_cnt == 0; n++) begin
            cycle();
            done_cnt += int'(done0);
        end
        wr_valid[0] = 0;
        check("t3_done_seen", 64'(done_cnt), 1);
        check("t3_done_phase", 64'(ph0), 0);
        check("t3_ready_after", 64'(rdy0), 1);
        repeat (4) cycle();
        check("t3_blocked_write", obs0[1], 0);

        // Extremes on every channel and beam
        do_reset();
        for (int b = 0; b < 2; b++) begin vi[0][b] = -128; vq[0][b] = -128; end
        for (int c = 0; c < 8; c++)
            for (int b = 0; b < 2; b++)
                for (int s = 0; s < 2; s++) write_w(0, c, b, s, -16);
        commit_wait(0);
        cycle(); cycle();
        for (int n = 0; n < 4; n++) begin
            for (int c = 0; c < 8; c++) check("t4_mix", obs0[c], T4[(m_phase[0] + 3) % 4]);
            cycle();
        end

        // Modes and channel enable
        do_reset();
        vq[0][0] = 4;
        for (int c = 0; c < 8; c++) write_w(0, c, 0, 0, 1);
        lo_mode[0] = 1;
        commit_wait(0);
        cycle(); cycle();
        for (int n = 0; n < 4; n++) begin
            check("t5_down", obs0[0], TD[(m_phase[0] + 3) % 4]);
            cycle();
        end
        lo_mode[0] = 0;
        cycle();
        for (int n = 0; n < 4; n++) begin
            check("t5_up", obs0[2], TU[(m_phase[0] + 3) % 4]);
            cycle();
        end
        lo_mode[0] = 2;
        cycle();
        check("t5_bypass", obs0[0], 0);
        lo_mode[0] = 0;
        ch_en[0] = 8'hF7;
        for (int n = 0; n < 4; n++) begin
            cycle();
            check("t5_ch3_off", obs0[3], 0);
            check("t5_ch4_on", obs0[4], TU[(m_phase[0] + 3) % 4]);
        end

        // Random writes, commits, syncs, modes on both instances
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            rand_inputs(0); rand_inputs(1);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
